// File: rtl/rv32i_pkg.sv
// Shared RV32I multi-cycle definitions: opcodes, datapath select encodings and controller states.
package rv32i_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_PC     = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_TRAP   = 4'd11
    } state_t;

    function automatic logic is_mem_op(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Request/ready handshake between the multi-cycle controller and the shared instruction/data memory.
interface multicycle_control_if;

    logic mem_req;
    logic mem_ready;
    logic IorD;
    logic MemRead;
    logic MemWrite;

    modport master (
        output mem_req,
        output IorD,
        output MemRead,
        output MemWrite,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        output mem_ready
    );

endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath selects, register enables and the memory handshake.
module multicycle_control
    import rv32i_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic                 Zero,
    multicycle_control_if.master mem,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 PCWriteCond,
    output logic [1:0]           PCSource,
    output logic [1:0]           ALUOp,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           MemtoReg,
    output logic                 RegWrite,
    output logic                 trap,
    output logic [3:0]           state_o
);

    state_t state_q;
    state_t state_d;

    // Zero qualifies PCWriteCond inside the datapath; the controller never needs it.
    logic unused_zero;
    assign unused_zero = Zero;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        mem.mem_req  = 1'b0;
        mem.IorD     = 1'b0;
        mem.MemRead  = 1'b0;
        mem.MemWrite = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        PCSource     = PCSRC_ALU;
        ALUOp        = ALUOP_ADD;
        ALUSrcA      = SRCA_PC;
        ALUSrcB      = SRCB_RS2;
        MemtoReg     = WB_ALUOUT;
        RegWrite     = 1'b0;
        trap         = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                mem.MemRead = 1'b1;
                ALUSrcB     = SRCB_FOUR;
                IRWrite     = mem.mem_ready;
                PCWrite     = mem.mem_ready;
                if (mem.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                if (is_mem_op(opcode))      state_d = S_MEMADR;
                else if (opcode == OP_R)    state_d = S_EXEC;
                else if (opcode == OP_I)    state_d = S_EXECI;
                else if (opcode == OP_BEQ)  state_d = S_BRANCH;
                else if (opcode == OP_JAL)  state_d = S_JAL;
                else                        state_d = TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem.mem_req = 1'b1;
                mem.MemRead = 1'b1;
                mem.IorD    = 1'b1;
                if (mem.mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = WB_MDR;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                mem.mem_req  = 1'b1;
                mem.MemWrite = 1'b1;
                mem.IorD     = 1'b1;
                if (mem.mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                ALUOp   = ALUOP_RFUNCT;
                state_d = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = ALUOP_IFUNCT;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = SRCA_RS1;
                ALUSrcB     = SRCB_RS2;
                ALUOp       = ALUOP_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                state_d     = S_FETCH;
            end
            S_JAL: begin
                RegWrite = 1'b1;
                MemtoReg = WB_PC;
                PCWrite  = 1'b1;
                PCSource = PCSRC_ALUOUT;
                state_d  = S_FETCH;
            end
            S_TRAP: begin
                trap = 1'b1;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        // Outputs are forced low while reset is held so an in-flight access is dropped at once.
        if (!rst_n) begin
            mem.mem_req  = 1'b0;
            mem.IorD     = 1'b0;
            mem.MemRead  = 1'b0;
            mem.MemWrite = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            PCWriteCond  = 1'b0;
            PCSource     = PCSRC_ALU;
            ALUOp        = ALUOP_ADD;
            ALUSrcA      = SRCA_PC;
            ALUSrcB      = SRCB_RS2;
            MemtoReg     = WB_ALUOUT;
            RegWrite     = 1'b0;
            trap         = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: trapping and non-trapping instances run side by side,
// per-cycle expected outputs queued when stimulus is applied and compared at the falling edge.
module tb_multicycle_control;
    import rv32i_pkg::*;

    typedef struct packed {
        logic       mem_req;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       PCWrite;
        logic       PCWriteCond;
        logic [1:0] PCSource;
        logic [1:0] ALUOp;
        logic [1:0] ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [1:0] MemtoReg;
        logic       RegWrite;
        logic       trap;
        logic [3:0] state;
    } obs_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       Zero;
    logic       mem_ready;

    logic       IRWrite, PCWrite, PCWriteCond, RegWrite, trap;
    logic [1:0] PCSource, ALUOp, ALUSrcA, ALUSrcB, MemtoReg;
    logic [3:0] state_o;

    logic       nt_IRWrite, nt_PCWrite, nt_PCWriteCond, nt_RegWrite, nt_trap;
    logic [1:0] nt_PCSource, nt_ALUOp, nt_ALUSrcA, nt_ALUSrcB, nt_MemtoReg;
    logic [3:0] nt_state_o;

    int tests = 0;
    int fails = 0;

    obs_t  exp_q[$];
    obs_t  exp_nt_q[$];
    string tag_q[$];

    obs_t obs;
    obs_t obs_nt;

    multicycle_control_if mif ();
    multicycle_control_if mif_nt ();

    assign mif.mem_ready    = mem_ready;
    assign mif_nt.mem_ready = mem_ready;

    always #5 clk = ~clk;

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .Zero(Zero), .mem(mif.master),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .PCSource(PCSource), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .trap(trap), .state_o(state_o)
    );

    multicycle_control #(.TRAP_ON_ILLEGAL(1'b0)) dut_nt (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .Zero(Zero), .mem(mif_nt.master),
        .IRWrite(nt_IRWrite), .PCWrite(nt_PCWrite), .PCWriteCond(nt_PCWriteCond),
        .PCSource(nt_PCSource), .ALUOp(nt_ALUOp), .ALUSrcA(nt_ALUSrcA), .ALUSrcB(nt_ALUSrcB),
        .MemtoReg(nt_MemtoReg), .RegWrite(nt_RegWrite), .trap(nt_trap), .state_o(nt_state_o)
    );

    assign obs = {mif.mem_req, mif.IorD, mif.MemRead, mif.MemWrite, IRWrite, PCWrite,
                  PCWriteCond, PCSource, ALUOp, ALUSrcA, ALUSrcB, MemtoReg, RegWrite,
                  trap, state_o};
    assign obs_nt = {mif_nt.mem_req, mif_nt.IorD, mif_nt.MemRead, mif_nt.MemWrite,
                     nt_IRWrite, nt_PCWrite, nt_PCWriteCond, nt_PCSource, nt_ALUOp,
                     nt_ALUSrcA, nt_ALUSrcB, nt_MemtoReg, nt_RegWrite, nt_trap, nt_state_o};

    // Output table of the controller, transcribed state by state from the datapath description.
    function automatic obs_t exp_out(input int st, input logic rdy);
        obs_t e = '0;
        e.state = 4'(st);
        case (st)
            0:  begin e.mem_req = 1; e.MemRead = 1; e.ALUSrcB = 2'b01;
                      e.IRWrite = rdy; e.PCWrite = rdy; end
            1:  begin e.ALUSrcA = 2'b10; e.ALUSrcB = 2'b10; end
            2:  begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; end
            3:  begin e.mem_req = 1; e.MemRead = 1; e.IorD = 1; end
            4:  begin e.RegWrite = 1; e.MemtoReg = 2'b01; end
            5:  begin e.mem_req = 1; e.MemWrite = 1; e.IorD = 1; end
            6:  begin e.ALUSrcA = 2'b01; e.ALUOp = 2'b10; end
            7:  begin e.ALUSrcA = 2'b01; e.ALUSrcB = 2'b10; e.ALUOp = 2'b11; end
            8:  begin e.RegWrite = 1; end
            9:  begin e.ALUSrcA = 2'b01; e.ALUOp = 2'b01; e.PCWriteCond = 1; e.PCSource = 2'b01; end
            10: begin e.RegWrite = 1; e.MemtoReg = 2'b10; e.PCWrite = 1; e.PCSource = 2'b01; end
            11: begin e.trap = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    task automatic compare(input string tag, input obs_t o, input obs_t e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [6:0] op, input logic z,
                                 input logic rdy, input int st, input int st_nt = -1);
        @(posedge clk);
        #1;
        opcode    = op;
        Zero      = z;
        mem_ready = rdy;
        exp_q.push_back(exp_out(st, rdy));
        exp_nt_q.push_back(exp_out((st_nt < 0) ? st : st_nt, rdy));
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        string tag;
        @(negedge clk);
        if (exp_q.size() == 0 || exp_nt_q.size() == 0 || tag_q.size() == 0) begin
            tests++;
            fails++;
            $error("[TB] FAIL scoreboard_empty observed=0 entries expected=1 entry");
        end else begin
            tag = tag_q.pop_front();
            compare(tag, obs, exp_q.pop_front());
            compare({tag, "_nt"}, obs_nt, exp_nt_q.pop_front());
        end
    endtask

    task automatic step(input string tag, input logic [6:0] op, input logic z,
                        input logic rdy, input int st, input int st_nt = -1);
        applyStimulus(tag, op, z, rdy, st, st_nt);
        checkOutput();
    endtask

    task automatic applyReset(input string tag);
        @(posedge clk);
        #1;
        rst_n     = 1'b0;
        mem_ready = 1'b0;
        @(negedge clk);
        compare(tag, obs, '0);
        compare({tag, "_nt"}, obs_nt, '0);
    endtask

    task automatic releaseReset(input string tag);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        exp_q.push_back(exp_out(0, 1'b0));
        exp_nt_q.push_back(exp_out(0, 1'b0));
        tag_q.push_back(tag);
        checkOutput();
    endtask

    initial begin
        rst_n     = 1'b0;
        opcode    = 7'd0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        compare("reset_outputs", obs, '0);
        compare("reset_outputs_nt", obs_nt, '0);
        releaseReset("reset_release");

        // Fetch stall for two cycles, then a full lw
        step("fetch_stall1", OP_LW, 1'b0, 1'b0, 0);
        step("fetch_stall2", OP_LW, 1'b0, 1'b0, 0);
        step("lw_fetch",     OP_LW, 1'b0, 1'b1, 0);
        step("lw_decode",    OP_LW, 1'b0, 1'b1, 1);
        step("lw_memadr",    OP_LW, 1'b0, 1'b1, 2);
        step("lw_memrd",     OP_LW, 1'b0, 1'b1, 3);
        step("lw_memwb",     OP_LW, 1'b0, 1'b1, 4);

        // sw with memory stalling three cycles
        step("sw_fetch",  OP_SW, 1'b0, 1'b1, 0);
        step("sw_decode", OP_SW, 1'b0, 1'b1, 1);
        step("sw_memadr", OP_SW, 1'b0, 1'b1, 2);
        step("sw_wait1",  OP_SW, 1'b0, 1'b0, 5);
        step("sw_wait2",  OP_SW, 1'b0, 1'b0, 5);
        step("sw_wait3",  OP_SW, 1'b0, 1'b0, 5);
        step("sw_ready",  OP_SW, 1'b0, 1'b1, 5);

        step("r_fetch",  OP_R, 1'b0, 1'b1, 0);
        step("r_decode", OP_R, 1'b0, 1'b1, 1);
        step("r_exec",   OP_R, 1'b0, 1'b1, 6);
        step("r_aluwb",  OP_R, 1'b0, 1'b1, 8);

        step("i_fetch",  OP_I, 1'b0, 1'b1, 0);
        step("i_decode", OP_I, 1'b0, 1'b1, 1);
        step("i_execi",  OP_I, 1'b0, 1'b1, 7);
        step("i_aluwb",  OP_I, 1'b0, 1'b1, 8);

        step("beq_z1_fetch",  OP_BEQ, 1'b1, 1'b1, 0);
        step("beq_z1_decode", OP_BEQ, 1'b1, 1'b1, 1);
        step("beq_z1_branch", OP_BEQ, 1'b1, 1'b1, 9);
        step("beq_z0_fetch",  OP_BEQ, 1'b0, 1'b1, 0);
        step("beq_z0_decode", OP_BEQ, 1'b0, 1'b1, 1);
        step("beq_z0_branch", OP_BEQ, 1'b0, 1'b1, 9);

        step("jal_fetch",  OP_JAL, 1'b0, 1'b1, 0);
        step("jal_decode", OP_JAL, 1'b0, 1'b1, 1);
        step("jal_jal",    OP_JAL, 1'b0, 1'b1, 10);

        // Illegal opcode: trapping instance sticks, the other falls back to fetch
        step("ill_fetch",  7'h7F, 1'b0, 1'b1, 0);
        step("ill_decode", 7'h7F, 1'b0, 1'b1, 1);
        step("ill_trap1",  7'h7F, 1'b0, 1'b0, 11, 0);
        step("ill_trap2",  OP_LW, 1'b0, 1'b0, 11, 0);
        step("ill_trap3",  OP_LW, 1'b0, 1'b1, 11, 0);

        applyReset("trap_reset");
        releaseReset("trap_release");

        // Reset asserted in the middle of a stalled load access
        step("mid_fetch",  OP_LW, 1'b0, 1'b1, 0);
        step("mid_decode", OP_LW, 1'b0, 1'b1, 1);
        step("mid_memadr", OP_LW, 1'b0, 1'b0, 2);
        step("mid_memrd",  OP_LW, 1'b0, 1'b0, 3);
        #2;
        rst_n = 1'b0;
        #1;
        compare("mid_reset_drop", obs, '0);
        compare("mid_reset_drop_nt", obs_nt, '0);
        releaseReset("mid_release");
        step("restart_fetch",  OP_LW, 1'b0, 1'b1, 0);
        step("restart_decode", OP_LW, 1'b0, 1'b1, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
